if_id_reg: RTL and testbench
============================

IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 Parameter ADDR_W, default 32, width of the next-address path.
REQ-002 Parameter INSTR_W, default 32, width of the instruction path.
REQ-003 Parameter NOP_INSTR, default all-zero INSTR_W value, bubble instruction loaded on reset and flush.
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, one clock; reset is synchronous and active-low (rst=0 resets on the next rising clk edge).
REQ-006 Port nextAddressIn, input, ADDR_W, PC+4 from the fetch stage.
REQ-007 Port instructionIn, input, INSTR_W, fetched instruction.
REQ-008 Port nextAddressOut, output, ADDR_W, registered PC+4 to the decode stage.
REQ-009 Port instructionOut, output, INSTR_W, registered instruction to the decode stage.
REQ-010 Port validOut, output, 1, high when the register holds a captured (non-bubble) fetch.
REQ-011 Ports stall and flush, input, 1 each, exist only when IF_ID_HAZARD_EN is defined (see Configuration).

Function
REQ-012 On each rising clk with rst=1 and no stall/flush: nextAddressOut<=nextAddressIn, instructionOut<=instructionIn, validOut<=1.
REQ-013 Latency exactly one cycle; outputs change only at rising clk, never combinationally from inputs.
REQ-014 Input changes between edges have no effect on outputs until the next rising edge.
REQ-015 No arithmetic; values pass bit-exact, no truncation or extension.
REQ-016 Priority at one edge: reset > flush > stall > capture.

Reset
REQ-017 rst=0 at a rising edge: nextAddressOut<=0, instructionOut<=NOP_INSTR, validOut<=0.
REQ-018 Reset asserted mid-operation overrides any pending capture on that edge; first capture occurs on the first rising edge with rst=1.
REQ-019 Reset is not sampled asynchronously; a pulse entirely between edges has no effect.

Configuration
REQ-020 Macro IF_ID_HAZARD_EN: when defined, stall and flush ports are present; when undefined, those ports are absent and the block behaves as a plain capture register.
REQ-021 With IF_ID_HAZARD_EN, stall=1 (rst=1, flush=0) holds all outputs unchanged.
REQ-022 With IF_ID_HAZARD_EN, flush=1 (rst=1) loads nextAddressOut<=0, instructionOut<=NOP_INSTR, validOut<=0, regardless of stall.

Structure
REQ-023 Shared package holds ADDR_W/INSTR_W defaults and NOP_INSTR constant, reused by other pipeline registers.
REQ-024 One sub-module is natural: pipe_reg (parameterised width, sync active-low reset value, enable, clear), instantiated once per field (address, instruction, valid).

Verification
REQ-025 rst=0 for two edges, inputs 60/40 -> outputs 0/NOP_INSTR, validOut=0.
REQ-026 rst=1, nextAddressIn=60, instructionIn=40 before an edge -> after that edge nextAddressOut=60, instructionOut=40, validOut=1.
REQ-027 Inputs changed to 64/0x8C010000 mid-cycle -> outputs stay 60/40 until the next rising edge, then update.
REQ-028 rst pulsed low for 10 ns not spanning an edge -> no change; rst low across an edge -> outputs 0/NOP_INSTR, validOut=0 after that edge.
REQ-029 (IF_ID_HAZARD_EN) stall=1 with new inputs 68/0x12345678 -> outputs hold previous 64/0x8C010000; stall=1 and flush=1 together -> 0/NOP_INSTR, validOut=0.

Source files
------------

// File: rtl/if_id_reg_pkg.sv
//------------------------------------------------------------------------------
// if_id_reg_pkg
// Shared widths and bubble encoding for the pipeline registers.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package if_id_reg_pkg;

  localparam int unsigned c_ADDR_W  = 32;
  localparam int unsigned c_INSTR_W = 32;

  // All-zero word doubles as the decode-stage bubble.
  localparam logic [c_INSTR_W-1:0] c_NOP_INSTR = '0;

  typedef struct packed {
    logic [c_ADDR_W-1:0]  nextAddress;
    logic [c_INSTR_W-1:0] instruction;
    logic                 valid;
  } ifIdFields_t;

endpackage

`default_nettype wire

// File: rtl/if_id_reg_pipe_reg.sv
//------------------------------------------------------------------------------
// pipe_reg
// Single pipeline field: sync active-low reset, clear beats enable.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_reg #(
  parameter int unsigned         WIDTH   = 32,
  parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data <= RST_VAL;
    end else if (clear) begin
      r_data <= RST_VAL;
    end else if (enable) begin
      r_data <= dataIn;
    end
  end

  assign dataOut = r_data;

endmodule

`default_nettype wire

// File: rtl/if_id_reg.sv
//------------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register; stall/flush present with IF_ID_HAZARD_EN defined.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_id_reg
  import if_id_reg_pkg::*;
#(
  parameter int unsigned          ADDR_W    = c_ADDR_W,
  parameter int unsigned          INSTR_W   = c_INSTR_W,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(c_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
`ifdef IF_ID_HAZARD_EN
  input  logic               stall,
  input  logic               flush,
`endif
  input  logic [ADDR_W-1:0]  nextAddressIn,
  input  logic [INSTR_W-1:0] instructionIn,
  output logic [ADDR_W-1:0]  nextAddressOut,
  output logic [INSTR_W-1:0] instructionOut,
  output logic               validOut
);

  logic w_enable;
  logic w_clear;

`ifdef IF_ID_HAZARD_EN
  // Flush outranks stall because clear is tested before enable in pipe_reg.
  assign w_enable = ~stall;
  assign w_clear  = flush;
`else
  assign w_enable = 1'b1;
  assign w_clear  = 1'b0;
`endif

  pipe_reg #(
    .WIDTH   (ADDR_W),
    .RST_VAL ({ADDR_W{1'b0}})
  ) u_addrReg (
    .clk     (clk),
    .rst     (rst),
    .enable  (w_enable),
    .clear   (w_clear),
    .dataIn  (nextAddressIn),
    .dataOut (nextAddressOut)
  );

  pipe_reg #(
    .WIDTH   (INSTR_W),
    .RST_VAL (NOP_INSTR)
  ) u_instrReg (
    .clk     (clk),
    .rst     (rst),
    .enable  (w_enable),
    .clear   (w_clear),
    .dataIn  (instructionIn),
    .dataOut (instructionOut)
  );

  pipe_reg #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_validReg (
    .clk     (clk),
    .rst     (rst),
    .enable  (w_enable),
    .clear   (w_clear),
    .dataIn  (1'b1),
    .dataOut (validOut)
  );

endmodule

`default_nettype wire

// File: tb/tb_if_id_reg.sv
//------------------------------------------------------------------------------
// tb_if_id_reg
// Directed bench for if_id_reg (hazard steps only with IF_ID_HAZARD_EN).
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_id_reg;

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] nextAddressIn;
  logic [31:0] instructionIn;
  logic [31:0] nextAddressOut;
  logic [31:0] instructionOut;
  logic        validOut;

  int errors = 0;
  int checks = 0;

  if_id_reg #(
    .ADDR_W    (32),
    .INSTR_W   (32),
    .NOP_INSTR (c_NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef IF_ID_HAZARD_EN
    .stall          (stall),
    .flush          (flush),
`endif
    .nextAddressIn  (nextAddressIn),
    .instructionIn  (instructionIn),
    .nextAddressOut (nextAddressOut),
    .instructionOut (instructionOut),
    .validOut       (validOut)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOut(input string tag, input logic [31:0] expAddr,
                          input logic [31:0] expInstr, input logic expValid);
    checks++;
    assert (nextAddressOut === expAddr) else begin
      errors++;
      $error("FAIL %s.addr observed=%h expected=%h", tag, nextAddressOut, expAddr);
    end
    checks++;
    assert (instructionOut === expInstr) else begin
      errors++;
      $error("FAIL %s.instr observed=%h expected=%h", tag, instructionOut, expInstr);
    end
    checks++;
    assert (validOut === expValid) else begin
      errors++;
      $error("FAIL %s.valid observed=%b expected=%b", tag, validOut, expValid);
    end
  endtask

  initial begin
    rst           = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    nextAddressIn = 32'd60;
    instructionIn = 32'd40;

    // Reset held for two edges while the inputs carry live data.
    stepEdge();
    stepEdge();
    checkOut("reset", 32'd0, c_NOP, 1'b0);

    rst = 1'b1;
    stepEdge();
    checkOut("capture60", 32'd60, 32'd40, 1'b1);

    // Mid-cycle input change must not leak through.
    #4;
    nextAddressIn = 32'd64;
    instructionIn = 32'h8C01_0000;
    #2;
    checkOut("midcycle", 32'd60, 32'd40, 1'b1);
    stepEdge();
    checkOut("capture64", 32'd64, 32'h8C01_0000, 1'b1);

    // Reset pulse strictly between edges.
    rst = 1'b0;
    #5;
    checkOut("rstpulse_in", 32'd64, 32'h8C01_0000, 1'b1);
    #5;
    rst = 1'b1;
    stepEdge();
    checkOut("rstpulse_after", 32'd64, 32'h8C01_0000, 1'b1);

`ifdef IF_ID_HAZARD_EN
    stall         = 1'b1;
    nextAddressIn = 32'd68;
    instructionIn = 32'h1234_5678;
    stepEdge();
    checkOut("stall", 32'd64, 32'h8C01_0000, 1'b1);
    stepEdge();
    checkOut("stall2", 32'd64, 32'h8C01_0000, 1'b1);

    flush = 1'b1;
    stepEdge();
    checkOut("flush_stall", 32'd0, c_NOP, 1'b0);

    stall = 1'b0;
    stepEdge();
    checkOut("flush_only", 32'd0, c_NOP, 1'b0);

    flush = 1'b0;
    stepEdge();
    checkOut("release", 32'd68, 32'h1234_5678, 1'b1);

    // Reset outranks flush and stall.
    stall = 1'b1;
    flush = 1'b1;
    rst   = 1'b0;
    nextAddressIn = 32'd72;
    stepEdge();
    checkOut("rst_over_hazard", 32'd0, c_NOP, 1'b0);
    rst   = 1'b1;
    flush = 1'b0;
    stall = 1'b0;
    stepEdge();
    checkOut("after_rst_hazard", 32'd72, 32'h1234_5678, 1'b1);
`endif

    // Reset across an edge with capture pending.
    nextAddressIn = 32'hFFFF_FFFF;
    instructionIn = 32'hA5A5_5A5A;
    rst = 1'b0;
    stepEdge();
    checkOut("rst_edge", 32'd0, c_NOP, 1'b0);

    rst = 1'b1;
    stepEdge();
    checkOut("allones", 32'hFFFF_FFFF, 32'hA5A5_5A5A, 1'b1);

    nextAddressIn = 32'h8000_0001;
    instructionIn = 32'h0000_0000;
    stepEdge();
    checkOut("zero_instr", 32'h8000_0001, 32'h0000_0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
